// File: rtl/issueque_int.sv
// Integer issue queue: compacting age-ordered buffer that snoops the CDB for
// operand wakeup and presents the oldest ready instruction to the issue unit.
module issueque_int #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_en,
  input  logic [3:0]       dispatch_opcode,
  input  logic [DATAW-1:0] dispatch_rsdata,
  input  logic [TAGW-1:0]  dispatch_rstag,
  input  logic             dispatch_rsvalid,
  input  logic [DATAW-1:0] dispatch_rtdata,
  input  logic [TAGW-1:0]  dispatch_rttag,
  input  logic             dispatch_rtvalid,
  input  logic [TAGW-1:0]  dispatch_rdtag,
  output logic             issueque_full,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tagout,
  input  logic [DATAW-1:0] cdb_out,
  input  logic             flush,
  output logic             ready_int,
  output logic [3:0]       issueque_opcode,
  output logic [DATAW-1:0] issueque_rsdata,
  output logic [DATAW-1:0] issueque_rtdata,
  output logic [TAGW-1:0]  issueque_rdtag,
  input  logic             issue_int
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [3:0]       opcode;
    logic [DATAW-1:0] rsdata;
    logic [TAGW-1:0]  rstag;
    logic             rsvalid;
    logic [DATAW-1:0] rtdata;
    logic [TAGW-1:0]  rttag;
    logic             rtvalid;
    logic [TAGW-1:0]  rdtag;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_nxt [DEPTH];
  entry_t           up    [DEPTH];
  entry_t           src;
  entry_t           din;
  logic [DEPTH-1:0] rdy;
  logic             do_issue;
  logic             disp_ok;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    wr_idx;

  // Wakeup applied to one entry; both operands may match the same broadcast.
  function automatic entry_t snoop(input entry_t e, input logic cv,
                                   input logic [TAGW-1:0] ct,
                                   input logic [DATAW-1:0] cd);
    entry_t r;
    r = e;
    if (cv && !e.rsvalid && e.rstag == ct) begin
      r.rsdata  = cd;
      r.rsvalid = 1'b1;
    end
    if (cv && !e.rtvalid && e.rttag == ct) begin
      r.rtdata  = cd;
      r.rtvalid = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    sel             = '0;
    cnt             = '0;
    ready_int       = 1'b0;
    issueque_opcode = '0;
    issueque_rsdata = '0;
    issueque_rtdata = '0;
    issueque_rdtag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = q[i].valid & q[i].rsvalid & q[i].rtvalid;
      if (q[i].valid) cnt = CW'(i + 1);
    end
    // Scan from the youngest so the oldest ready entry wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        ready_int       = 1'b1;
        sel             = CW'(i);
        issueque_opcode = q[i].opcode;
        issueque_rsdata = q[i].rsdata;
        issueque_rtdata = q[i].rtdata;
        issueque_rdtag  = q[i].rdtag;
      end
    end
  end

  assign issueque_full = q[DEPTH-1].valid;
  assign do_issue      = issue_int & ready_int;
  assign disp_ok       = dispatch_en & ~issueque_full;
  assign wr_idx        = cnt - CW'(do_issue);

  always_comb begin
    din         = '0;
    din.valid   = 1'b1;
    din.opcode  = dispatch_opcode;
    din.rsdata  = dispatch_rsdata;
    din.rstag   = dispatch_rstag;
    din.rsvalid = dispatch_rsvalid;
    din.rtdata  = dispatch_rtdata;
    din.rttag   = dispatch_rttag;
    din.rtvalid = dispatch_rtvalid;
    din.rdtag   = dispatch_rdtag;
    for (int i = 0; i < DEPTH - 1; i++) up[i] = q[i+1];
    up[DEPTH-1] = '0;
    src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src      = (do_issue && CW'(i) >= sel) ? up[i] : q[i];
      q_nxt[i] = '0;
      if (src.valid)
        q_nxt[i] = snoop(src, cdb_valid, cdb_tagout, cdb_out);
      else if (disp_ok && wr_idx == CW'(i))
        q_nxt[i] = snoop(din, cdb_valid, cdb_tagout, cdb_out);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
    end
  end

endmodule

// File: tb/tb_issueque_int.sv
// Directed bench for issueque_int: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the test plan.
module tb_issueque_int;
  localparam int DEPTH = 4;
  localparam int TAGW  = 6;
  localparam int DATAW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             dispatch_en;
  logic [3:0]       dispatch_opcode;
  logic [DATAW-1:0] dispatch_rsdata;
  logic [TAGW-1:0]  dispatch_rstag;
  logic             dispatch_rsvalid;
  logic [DATAW-1:0] dispatch_rtdata;
  logic [TAGW-1:0]  dispatch_rttag;
  logic             dispatch_rtvalid;
  logic [TAGW-1:0]  dispatch_rdtag;
  logic             issueque_full;
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tagout;
  logic [DATAW-1:0] cdb_out;
  logic             flush;
  logic             ready_int;
  logic [3:0]       issueque_opcode;
  logic [DATAW-1:0] issueque_rsdata;
  logic [DATAW-1:0] issueque_rtdata;
  logic [TAGW-1:0]  issueque_rdtag;
  logic             issue_int;

  int tests = 0;
  int fails = 0;

  issueque_int #(.DEPTH(DEPTH), .TAGW(TAGW), .DATAW(DATAW)) dut (
    .clk(clk), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rstag(dispatch_rstag),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rttag(dispatch_rttag), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_rdtag(dispatch_rdtag), .issueque_full(issueque_full),
    .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
    .flush(flush), .ready_int(ready_int), .issueque_opcode(issueque_opcode),
    .issueque_rsdata(issueque_rsdata), .issueque_rtdata(issueque_rtdata),
    .issueque_rdtag(issueque_rdtag), .issue_int(issue_int)
  );

  always #5 clk = ~clk;

  // Reference model: an age-ordered list of instructions.
  typedef struct {
    logic [3:0]       op;
    logic [DATAW-1:0] rs;
    logic [DATAW-1:0] rt;
    logic [TAGW-1:0]  rst;
    logic [TAGW-1:0]  rtt;
    logic [TAGW-1:0]  rd;
    bit               rsv;
    bit               rtv;
  } m_t;

  m_t mq[$];

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].rsv && mq[i].rtv) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      mq.delete();
    end else begin
      int k;
      bit was_full;
      m_t n;
      k = oldest_ready();
      was_full = (mq.size() == DEPTH);
      if (issue_int && k >= 0) mq.delete(k);
      if (dispatch_en && !was_full) begin
        n.op = dispatch_opcode; n.rs = dispatch_rsdata; n.rt = dispatch_rtdata;
        n.rst = dispatch_rstag; n.rtt = dispatch_rttag; n.rd = dispatch_rdtag;
        n.rsv = dispatch_rsvalid; n.rtv = dispatch_rtvalid;
        mq.push_back(n);
      end
      if (cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].rsv && mq[i].rst == cdb_tagout) begin mq[i].rs = cdb_out; mq[i].rsv = 1; end
          if (!mq[i].rtv && mq[i].rtt == cdb_tagout) begin mq[i].rt = cdb_out; mq[i].rtv = 1; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      int k;
      logic [31:0] e_op, e_rs, e_rt, e_rd;
      k = oldest_ready();
      e_op = 0; e_rs = 0; e_rt = 0; e_rd = 0;
      if (k >= 0) begin
        e_op = 32'(mq[k].op); e_rs = 32'(mq[k].rs); e_rt = 32'(mq[k].rt); e_rd = 32'(mq[k].rd);
      end
      check("model_ready", 32'(ready_int), (k >= 0) ? 1 : 0);
      check("model_full", 32'(issueque_full), (mq.size() == DEPTH) ? 1 : 0);
      check("model_opcode", 32'(issueque_opcode), e_op);
      check("model_rsdata", 32'(issueque_rsdata), e_rs);
      check("model_rtdata", 32'(issueque_rtdata), e_rt);
      check("model_rdtag", 32'(issueque_rdtag), e_rd);
    end
  end

  task automatic idle();
    dispatch_en = 0; dispatch_opcode = 0; dispatch_rsdata = 0; dispatch_rstag = 0;
    dispatch_rsvalid = 0; dispatch_rtdata = 0; dispatch_rttag = 0; dispatch_rtvalid = 0;
    dispatch_rdtag = 0; cdb_valid = 0; cdb_tagout = 0; cdb_out = 0; flush = 0; issue_int = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic [5:0] rst,
                      input logic rsv, input logic [31:0] rt, input logic [5:0] rtt,
                      input logic rtv, input logic [5:0] rd);
    dispatch_en = 1; dispatch_opcode = op;
    dispatch_rsdata = rs; dispatch_rstag = rst; dispatch_rsvalid = rsv;
    dispatch_rtdata = rt; dispatch_rttag = rtt; dispatch_rtvalid = rtv;
    dispatch_rdtag = rd;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tagout = tag; cdb_out = data;
  endtask

  initial begin
    idle();
    reset = 0;
    tick();
    check("rst_ready", 32'(ready_int), 0);
    check("rst_full", 32'(issueque_full), 0);
    check("rst_rsdata", 32'(issueque_rsdata), 0);
    check("rst_rdtag", 32'(issueque_rdtag), 0);
    reset = 1;
    tick();

    // Immediate issue of a fully ready instruction.
    disp(4'h0, 32'hA, 6'h0, 1, 32'h5, 6'h0, 1, 6'h0E);
    issue_int = 1;
    tick();
    dispatch_en = 0;
    check("t1_ready", 32'(ready_int), 1);
    check("t1_rsdata", 32'(issueque_rsdata), 32'hA);
    check("t1_rtdata", 32'(issueque_rtdata), 32'h5);
    check("t1_rdtag", 32'(issueque_rdtag), 32'h0E);
    tick();
    issue_int = 0;
    check("t1_gone", 32'(ready_int), 0);

    // Younger ready entry issues ahead of an older pending one until wakeup.
    disp(4'h1, 32'h0, 6'h03, 0, 32'h11, 6'h0, 1, 6'h10);
    tick();
    disp(4'h2, 32'h22, 6'h0, 1, 32'h33, 6'h0, 1, 6'h11);
    tick();
    idle();
    check("t2_b_first", 32'(issueque_opcode), 32'h2);
    check("t2_b_rdtag", 32'(issueque_rdtag), 32'h11);
    cdb(6'h03, 32'h77);
    tick();
    idle();
    check("t2_a_op", 32'(issueque_opcode), 32'h1);
    check("t2_a_rsdata", 32'(issueque_rsdata), 32'h77);
    check("t2_a_rdtag", 32'(issueque_rdtag), 32'h10);
    issue_int = 1;
    tick();
    check("t2_b_next", 32'(issueque_opcode), 32'h2);
    tick();
    issue_int = 0;
    check("t2_empty", 32'(ready_int), 0);

    // Fill, drop on full, wake and issue a middle entry.
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'(4 + i), 32'h0, 6'(6'h20 + i), 0, 32'(i), 6'h0, 1, 6'(6'h30 + i));
      tick();
    end
    check("t3_full", 32'(issueque_full), 1);
    check("t3_none_ready", 32'(ready_int), 0);
    disp(4'hF, 32'h1, 6'h0, 1, 32'h2, 6'h0, 1, 6'h3F);
    tick();
    idle();
    check("t3_drop_full", 32'(issueque_full), 1);
    check("t3_drop_ready", 32'(ready_int), 0);
    cdb(6'h22, 32'hCAFE);
    tick();
    idle();
    check("t3_wake_rd", 32'(issueque_rdtag), 32'h32);
    check("t3_wake_rs", 32'(issueque_rsdata), 32'hCAFE);
    issue_int = 1;
    tick();
    issue_int = 0;
    check("t3_notfull", 32'(issueque_full), 0);
    check("t3_after_ready", 32'(ready_int), 0);
    cdb(6'h23, 32'hBEEF);
    tick();
    idle();
    check("t3_shift_rd", 32'(issueque_rdtag), 32'h33);
    check("t3_shift_rs", 32'(issueque_rsdata), 32'hBEEF);
    disp(4'h8, 32'h0, 6'h24, 0, 32'h0, 6'h0, 1, 6'h34);
    tick();
    idle();
    check("t3_refull", 32'(issueque_full), 1);
    issue_int = 1;
    tick();
    issue_int = 0;
    check("t3_three_left", 32'(issueque_full), 0);

    // Flush beats a concurrent dispatch.
    flush = 1;
    disp(4'h9, 32'h1, 6'h0, 1, 32'h2, 6'h0, 1, 6'h01);
    tick();
    idle();
    check("t4_flush_ready", 32'(ready_int), 0);
    check("t4_flush_full", 32'(issueque_full), 0);
    tick();
    check("t4_still_empty", 32'(ready_int), 0);

    // Dispatch collides with a matching CDB broadcast.
    disp(4'h3, 32'h1, 6'h0, 1, 32'h0, 6'h09, 0, 6'h09);
    cdb(6'h09, 32'h1234);
    tick();
    idle();
    check("t5_ready", 32'(ready_int), 1);
    check("t5_rtdata", 32'(issueque_rtdata), 32'h1234);

    // Wakeup lands on an entry that shifts down in the same edge.
    disp(4'h6, 32'h0, 6'h2A, 0, 32'h66, 6'h0, 1, 6'h2A);
    tick();
    idle();
    issue_int = 1;
    cdb(6'h2A, 32'hABCD);
    tick();
    idle();
    check("t6_rdtag", 32'(issueque_rdtag), 32'h2A);
    check("t6_rsdata", 32'(issueque_rsdata), 32'hABCD);
    issue_int = 1;
    tick();
    issue_int = 0;
    check("t6_empty", 32'(ready_int), 0);

    // One broadcast satisfies both operands.
    disp(4'h7, 32'h0, 6'h15, 0, 32'h0, 6'h15, 0, 6'h15);
    tick();
    idle();
    cdb(6'h15, 32'h55);
    tick();
    idle();
    check("t7_rs", 32'(issueque_rsdata), 32'h55);
    check("t7_rt", 32'(issueque_rtdata), 32'h55);

    // Asynchronous reset mid-cycle drops the pending entry.
    #2;
    reset = 0;
    #1;
    check("t8_async_ready", 32'(ready_int), 0);
    check("t8_async_rt", 32'(issueque_rtdata), 0);
    tick();
    reset = 1;
    tick();
    check("t8_post_ready", 32'(ready_int), 0);
    check("t8_post_full", 32'(issueque_full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
